ext_to_affine: RTL

- Output end of the Ed25519 point pipeline: converts an extended/projective point (X:Y:Z), as produced by PointAdd, back to affine x = X/Z, y = Y/Z mod N, where N = 2^255-19.
- The inverse is Z^(N-2) mod N by Fermat exponentiation, scanned MSB-first, on the existing Montgomery multiplier. Two final multiplies produce x and y.
- Sits between the scalar-multiply controller and the result/encode stage. The T coordinate is not consumed.

---
 rtl/ed25519_pkg.sv | 39 +++
 rtl/ext_to_affine_if.sv | 37 +++
 rtl/fe_invert.sv | 115 +++++++++++
 rtl/mont_mul.sv | 59 +++++
 rtl/ext_to_affine.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/ed25519_pkg.sv
// Shared Ed25519 field constants and the point-conversion state encoding.
// Field: N = 2^255-19, Montgomery radix R = 2^255.
package ed25519_pkg;

    localparam int unsigned FE_W = 255;

    typedef logic [FE_W-1:0]   fe_t;
    typedef logic [FE_W:0]     fe1_t;
    typedef logic [2*FE_W-1:0] dbl_t;
    typedef logic [2*FE_W:0]   sum_t;

    localparam fe_t N        = '1 - fe_t'(18);
    localparam fe_t R_MOD_N  = fe_t'(19);
    localparam fe_t R2_MOD_N = fe_t'(361);
    localparam fe_t EXP_INV  = N - fe_t'(2);

    // Inverse of an odd value modulo 2^255 by Newton iteration; each step
    // doubles the number of correct low bits (1 -> 256 after 8 steps).
    function automatic fe_t inv_mod_r(input fe_t a);
        fe_t x;
        x = fe_t'(1);
        for (int unsigned i = 0; i < 8; i++) begin
            x = x * (fe_t'(2) - a * x);
        end
        return x;
    endfunction

    // -N^-1 mod R. Since N = -19 mod R, this is simply 19^-1 mod R.
    localparam fe_t N_PRIME = inv_mod_r(fe_t'(19));

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOMONT,
        S_SQR,
        S_MUL,
        S_FINAL
    } state_t;

endpackage

// File: rtl/ext_to_affine_if.sv
// Request/response bundle for the projective-to-affine converter.
// Optional macro COMPRESS_OUT_EN adds the 256-bit encoded point o_enc.
interface ext_to_affine_if #(
    parameter int unsigned WIDTH = 255
);
    logic             i_start;
    logic [WIDTH-1:0] i_x;
    logic [WIDTH-1:0] i_y;
    logic [WIDTH-1:0] i_z;
    logic [WIDTH-1:0] o_x;
    logic [WIDTH-1:0] o_y;
    logic             o_busy;
    logic             o_finished;
`ifdef COMPRESS_OUT_EN
    logic [WIDTH:0]   o_enc;

    modport master (
        output i_start, i_x, i_y, i_z,
        input  o_x, o_y, o_busy, o_finished, o_enc
    );

    modport slave (
        input  i_start, i_x, i_y, i_z,
        output o_x, o_y, o_busy, o_finished, o_enc
    );
`else
    modport master (
        output i_start, i_x, i_y, i_z,
        input  o_x, o_y, o_busy, o_finished
    );

    modport slave (
        input  i_start, i_x, i_y, i_z,
        output o_x, o_y, o_busy, o_finished
    );
`endif
endinterface

// File: rtl/fe_invert.sv
// Field inversion Z^(N-2) mod N, result left in the Montgomery domain
// (Z^-1 * R). Drives an external Montgomery multiplier through a registered
// request (start/a/b) and consumes its finished/result.
module fe_invert
    import ed25519_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  fe_t  i_z,
    output logic o_finished,
    output fe_t  o_result,
    output logic o_mul_start,
    output fe_t  o_mul_a,
    output fe_t  o_mul_b,
    input  logic i_mul_finished,
    input  fe_t  i_mul_result
);

    state_t     state_q, state_n;
    logic [7:0] k_q, k_n;
    fe_t        zm_q, zm_n;
    fe_t        a_q, a_n;
    fe_t        b_q, b_n;
    logic       start_q, start_n;

    // Square-and-multiply sequencing; the multiplier operands double as acc
    always_comb begin
        state_n    = state_q;
        k_n        = k_q;
        zm_n       = zm_q;
        a_n        = a_q;
        b_n        = b_q;
        start_n    = 1'b0;
        o_finished = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    a_n     = i_z;
                    b_n     = R2_MOD_N;
                    start_n = 1'b1;
                    state_n = S_TOMONT;
                end
            end
            S_TOMONT: begin
                if (i_mul_finished) begin
                    zm_n    = i_mul_result;
                    k_n     = 8'd254;
                    a_n     = R_MOD_N;
                    b_n     = R_MOD_N;
                    start_n = 1'b1;
                    state_n = S_SQR;
                end
            end
            S_SQR: begin
                if (i_mul_finished) begin
                    if (EXP_INV[k_q]) begin
                        a_n     = i_mul_result;
                        b_n     = zm_q;
                        start_n = 1'b1;
                        state_n = S_MUL;
                    end else if (k_q == 8'd0) begin
                        o_finished = 1'b1;
                        state_n    = S_IDLE;
                    end else begin
                        k_n     = k_q - 8'd1;
                        a_n     = i_mul_result;
                        b_n     = i_mul_result;
                        start_n = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (i_mul_finished) begin
                    if (k_q == 8'd0) begin
                        o_finished = 1'b1;
                        state_n    = S_IDLE;
                    end else begin
                        k_n     = k_q - 8'd1;
                        a_n     = i_mul_result;
                        b_n     = i_mul_result;
                        start_n = 1'b1;
                        state_n = S_SQR;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign o_result    = i_mul_result;
    assign o_mul_start = start_q;
    assign o_mul_a     = a_q;
    assign o_mul_b     = b_q;

    // State, bit counter and registered multiplier request
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            zm_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_n;
            k_q     <= k_n;
            zm_q    <= zm_n;
            a_q     <= a_n;
            b_q     <= b_n;
            start_q <= start_n;
        end
    end

endmodule

// File: rtl/mont_mul.sv
// Montgomery multiplier mod N: o_result = a*b*R^-1 mod N, R = 2^255.
// Three pipeline stages; o_finished pulses three cycles after i_start.
// Operands must be < N; the result is fully reduced.
module mont_mul
    import ed25519_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  fe_t  i_a,
    input  fe_t  i_b,
    output fe_t  o_result,
    output logic o_finished
);

    dbl_t t_q;
    dbl_t t2_q;
    fe_t  m_q;
    logic v1_q;
    logic v2_q;
    sum_t sum;
    fe1_t u;
    fe_t  red;

    // REDC tail: (T + m*N) is divisible by R; quotient < 2N, one subtract
    always_comb begin
        sum = sum_t'(t2_q) + sum_t'(m_q) * sum_t'(N);
        u   = fe1_t'(sum >> FE_W);
        red = (u >= fe1_t'(N)) ? fe_t'(u - fe1_t'(N)) : fe_t'(u);
    end

    // Pipeline: product, reduction factor, reduced result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            t_q        <= '0;
            t2_q       <= '0;
            m_q        <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            o_result   <= '0;
            o_finished <= 1'b0;
        end else begin
            v1_q       <= i_start;
            v2_q       <= v1_q;
            o_finished <= v2_q;
            if (i_start) begin
                t_q <= dbl_t'(i_a) * dbl_t'(i_b);
            end
            if (v1_q) begin
                t2_q <= t_q;
                m_q  <= fe_t'(t_q[FE_W-1:0] * N_PRIME);
            end
            if (v2_q) begin
                o_result <= red;
            end
        end
    end

endmodule

// File: rtl/ext_to_affine.sv
// Projective (X:Y:Z) to affine (X/Z, Y/Z) mod 2^255-19.
// Optional macro COMPRESS_OUT_EN adds o_enc = {x[0], y}.
module ext_to_affine
    import ed25519_pkg::*;
#(
    parameter int unsigned WIDTH = 255
) (
    input  logic           i_clk,
    input  logic           i_rst,
    ext_to_affine_if.slave bus
);

    if (WIDTH != 255) begin : g_width_chk
        $error("ext_to_affine supports only WIDTH = 255");
    end

    state_t state_q, state_n;
    fe_t    x_q, x_n;
    fe_t    y_q, y_n;
    fe_t    inv_q, inv_n;
    logic   fs_q, fs_n;
    fe_t    ox_q, ox_n;
    fe_t    oy_q, oy_n;
    logic   fin_q, fin_n;
    logic   busy_q, busy_n;
`ifdef COMPRESS_OUT_EN
    logic [FE_W:0] enc_q, enc_n;
`endif

    logic inv_start;
    logic inv_finished;
    fe_t  inv_result;
    logic inv_mul_start;
    fe_t  inv_mul_a;
    fe_t  inv_mul_b;

    logic m0_start;
    fe_t  m0_a;
    fe_t  m0_b;
    fe_t  m0_res;
    logic m0_finished;
    logic m1_start;
    fe_t  m1_res;
    logic m1_finished;

    fe_invert u_inv (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (inv_start),
        .i_z            (bus.i_z),
        .o_finished     (inv_finished),
        .o_result       (inv_result),
        .o_mul_start    (inv_mul_start),
        .o_mul_a        (inv_mul_a),
        .o_mul_b        (inv_mul_b),
        .i_mul_finished (m0_finished),
        .i_mul_result   (m0_res)
    );

    // m0 is shared: the inverter owns it until S_FINAL
    assign m0_start = inv_mul_start | fs_q;
    assign m0_a     = (state_q == S_FINAL) ? x_q   : inv_mul_a;
    assign m0_b     = (state_q == S_FINAL) ? inv_q : inv_mul_b;
    assign m1_start = fs_q;

    mont_mul u_m0 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (m0_start),
        .i_a        (m0_a),
        .i_b        (m0_b),
        .o_result   (m0_res),
        .o_finished (m0_finished)
    );

    mont_mul u_m1 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (m1_start),
        .i_a        (y_q),
        .i_b        (inv_q),
        .o_result   (m1_res),
        .o_finished (m1_finished)
    );

    // Top-level sequencing; S_TOMONT here covers the whole inversion
    always_comb begin
        state_n   = state_q;
        x_n       = x_q;
        y_n       = y_q;
        inv_n     = inv_q;
        fs_n      = 1'b0;
        ox_n      = ox_q;
        oy_n      = oy_q;
        fin_n     = 1'b0;
        inv_start = 1'b0;
`ifdef COMPRESS_OUT_EN
        enc_n     = enc_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    x_n       = bus.i_x;
                    y_n       = bus.i_y;
                    inv_start = 1'b1;
                    state_n   = S_TOMONT;
                end
            end
            S_TOMONT: begin
                if (inv_finished) begin
                    inv_n   = inv_result;
                    fs_n    = 1'b1;
                    state_n = S_FINAL;
                end
            end
            S_FINAL: begin
                // m0 and m1 start together and have equal latency
                if (m0_finished && m1_finished) begin
                    ox_n    = m0_res;
                    oy_n    = m1_res;
                    fin_n   = 1'b1;
                    state_n = S_IDLE;
`ifdef COMPRESS_OUT_EN
                    enc_n   = {m0_res[0], m1_res};
`endif
                end
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n != S_IDLE) || fin_n;
    end

    // State, captured coordinates and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            inv_q   <= '0;
            fs_q    <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef COMPRESS_OUT_EN
            enc_q   <= '0;
`endif
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            inv_q   <= inv_n;
            fs_q    <= fs_n;
            ox_q    <= ox_n;
            oy_q    <= oy_n;
            fin_q   <= fin_n;
            busy_q  <= busy_n;
`ifdef COMPRESS_OUT_EN
            enc_q   <= enc_n;
`endif
        end
    end

    assign bus.o_x        = ox_q;
    assign bus.o_y        = oy_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_finished = fin_q;
`ifdef COMPRESS_OUT_EN
    assign bus.o_enc      = enc_q;
`endif

endmodule
